store_checker: RTL and testbench
================================

STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 32, write-data width.
- ADDR_W, 32, address width.
- DEPTH, 4, expected-store table entries.
- TIMEOUT, 1000, RUN cycles before timeout failure.
- IGNORE_EN, 1, enables the tolerated scratch address.
- IGNORE_ADDR, 80, address whose stores are tolerated.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, begin a check run.
- tbl_we, in, 1, table write enable.
- tbl_idx, in, $clog2(DEPTH), table entry index.
- tbl_addr, in, ADDR_W, expected address.
- tbl_data, in, DATA_W, expected data.
- num_exp, in, $clog2(DEPTH+1), entries to check; sampled on start.
- memwrite, in, 1, CPU store strobe.
- dataadr, in, ADDR_W, store address.
- writedata, in, DATA_W, store data.
- busy, out, 1, state is RUN.
- done, out, 1, state is PASS or FAIL.
- pass, out, 1, state is PASS.
- fail_code, out, 2, 0 none, 1 mismatch, 2 timeout.
- match_cnt, out, $clog2(DEPTH+1), stores matched.
- cycles, out, 32, RUN cycles elapsed.
REQ-003 clk is the sole clock; reset is synchronous and active-high; all state updates on the rising edge of clk.

Function
REQ-004 FSM states: IDLE, RUN, PASS, FAIL.
REQ-005 IDLE: tbl_we=1 writes (tbl_addr, tbl_data) into entry tbl_idx at the next edge; tbl_idx>=DEPTH is ignored.
REQ-006 IDLE->RUN on start=1. Same edge: latch num_exp, clear ptr, match_cnt, cycles and fail_code.
REQ-007 start=1 with num_exp=0 goes IDLE->PASS directly.
REQ-008 start=1 in PASS or FAIL behaves as in IDLE and re-arms a run with the current table contents.
REQ-009 RUN with memwrite=0: cycles increments; no other effect.
REQ-010 RUN with memwrite=1 and dataadr/writedata equal to entry[ptr]:
- ptr and match_cnt increment.
- If this was entry num_exp-1, next state is PASS.
REQ-011 RUN with memwrite=1, no match, IGNORE_EN=1 and dataadr==IGNORE_ADDR: the store is ignored and the state is unchanged.
REQ-012 Any other RUN store goes to FAIL with fail_code=1 on the next edge.
REQ-013 Priority: an expected-entry match beats the ignore rule, even when the entry address equals IGNORE_ADDR.
REQ-014 When cycles reaches TIMEOUT-1 in RUN without completing, the next state is FAIL with fail_code=2.
REQ-015 A completing match in the same cycle as timeout gives PASS. A mismatch in the same cycle as timeout gives fail_code=1.
REQ-016 tbl_we is ignored in RUN.
REQ-017 PASS and FAIL are sticky: outputs hold until reset or start. cycles saturates and does not wrap.
REQ-018 Outputs are registered or decoded from state only. done/pass/fail_code become valid on the edge that captures the deciding store (1-cycle latency).

Reset
REQ-019 reset=1 at an edge forces IDLE and clears busy, done, pass, fail_code, match_cnt, cycles and ptr to 0, including mid-RUN.
REQ-020 Table contents are not cleared by reset.
REQ-021 reset has priority over start and tbl_we in the same cycle.

Structure
REQ-022 Package store_checker_pkg holds:
- state enum (IDLE, RUN, PASS, FAIL);
- fail-code constants FC_NONE=0, FC_MISMATCH=1, FC_TIMEOUT=2.
REQ-023 One sub-module, expect_table: DEPTH x (ADDR_W+DATA_W) register file with one write port and one asynchronous read port indexed by ptr.

Verification
REQ-024 Pass case:
- Setup: entry0=(84,8), num_exp=1; stores (80,7) then (84,8).
- Expect: pass=1, done=1, fail_code=0, match_cnt=1.
REQ-025 Mismatch case:
- Setup: entry0=(84,8); store (88,8).
- Expect: next edge FAIL, fail_code=1, match_cnt=0.
REQ-026 Timeout case:
- Setup: TIMEOUT=16, start, no stores.
- Expect: FAIL with fail_code=2 on the 16th RUN edge; cycles=15.
REQ-027 Ordering case:
- Setup: DEPTH=4, three entries (84,8),(88,9),(92,10).
- In-order stores: pass, match_cnt=3.
- Stores 84 then 92: fail_code=1, match_cnt=1.
REQ-028 Reset/table-lock case:
- reset mid-RUN: all outputs 0 next edge.
- tbl_we during RUN: entry unchanged.
- start again: run succeeds.
REQ-029 Simultaneous case: last matching store in the timeout cycle -> pass=1, fail_code=0.

Source files
------------

// File: rtl/store_checker_pkg.sv
// rtl/store_checker_pkg.sv - shared state and fail-code definitions for store_checker
package store_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_e;

   localparam logic [1:0] FC_NONE     = 2'd0;
   localparam logic [1:0] FC_MISMATCH = 2'd1;
   localparam logic [1:0] FC_TIMEOUT  = 2'd2;

endpackage

// File: rtl/store_checker_expect_table.sv
// rtl/store_checker_expect_table.sv - expected-store register file, one write port, async read
module expect_table #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   widx_i,
   input  logic [ADDR_W-1:0]          waddr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   input  logic [$clog2(DEPTH)-1:0]   ridx_i,
   output logic [ADDR_W-1:0]          raddr_o,
   output logic [DATA_W-1:0]          rdata_o
);

   // Contents deliberately survive reset so a run can be re-armed without reloading.
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i && (32'(widx_i) < DEPTH)) begin
         addr_q[widx_i] <= waddr_i;
         data_q[widx_i] <= wdata_i;
      end
   end

   assign raddr_o = addr_q[ridx_i];
   assign rdata_o = data_q[ridx_i];

endmodule

// File: rtl/store_checker.sv
// rtl/store_checker.sv - watches CPU stores and checks them against an ordered expected-store table
module store_checker
   import store_checker_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT     = 1000,
   parameter int IGNORE_EN   = 1,
   parameter int IGNORE_ADDR = 80
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         tbl_we,
   input  logic [$clog2(DEPTH)-1:0]     tbl_idx,
   input  logic [ADDR_W-1:0]            tbl_addr,
   input  logic [DATA_W-1:0]            tbl_data,
   input  logic [$clog2(DEPTH+1)-1:0]   num_exp,
   input  logic                         memwrite,
   input  logic [ADDR_W-1:0]            dataadr,
   input  logic [DATA_W-1:0]            writedata,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [1:0]                   fail_code,
   output logic [$clog2(DEPTH+1)-1:0]   match_cnt,
   output logic [31:0]                  cycles
);

   localparam int                IW      = $clog2(DEPTH);
   localparam int                CW      = $clog2(DEPTH+1);
   localparam logic [31:0]       TO_LAST = 32'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] IGN_A   = ADDR_W'(IGNORE_ADDR);
   localparam logic [CW-1:0]     NUM_MAX = CW'(DEPTH);

   state_e            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]     num_q, num_d;
   logic [CW-1:0]     match_q, match_d;
   logic [31:0]       cyc_q, cyc_d;
   logic [1:0]        fc_q, fc_d;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_data;
   logic              hit, ignorable, timeout, last;

   expect_table #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_table (
      .clk_i   (clk),
      .we_i    (tbl_we && !reset && (state_q != ST_RUN)),
      .widx_i  (tbl_idx),
      .waddr_i (tbl_addr),
      .wdata_i (tbl_data),
      .ridx_i  (ptr_q),
      .raddr_o (exp_addr),
      .rdata_o (exp_data)
   );

   assign hit       = memwrite && (dataadr == exp_addr) && (writedata == exp_data);
   assign ignorable = (IGNORE_EN != 0) && (dataadr == IGN_A);
   assign timeout   = (cyc_q == TO_LAST);
   assign last      = ((match_q + CW'(1)) == num_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      num_d   = num_q;
      match_d = match_q;
      cyc_d   = cyc_q;
      fc_d    = fc_q;
      if (state_q == ST_RUN) begin
         // cycles parks at TIMEOUT-1, which is also what stops it from wrapping.
         if (!timeout) cyc_d = cyc_q + 32'd1;
         if (hit) begin
            ptr_d   = ptr_q + IW'(1);
            match_d = match_q + CW'(1);
            if (last) begin
               state_d = ST_PASS;
            end else if (timeout) begin
               state_d = ST_FAIL;
               fc_d    = FC_TIMEOUT;
            end
         end else if (memwrite && !ignorable) begin
            state_d = ST_FAIL;
            fc_d    = FC_MISMATCH;
         end else if (timeout) begin
            state_d = ST_FAIL;
            fc_d    = FC_TIMEOUT;
         end
      end else if (start) begin
         // Asking for more entries than the table holds is clamped to a full table.
         num_d   = (num_exp > NUM_MAX) ? NUM_MAX : num_exp;
         ptr_d   = '0;
         match_d = '0;
         cyc_d   = '0;
         fc_d    = FC_NONE;
         state_d = (num_exp == '0) ? ST_PASS : ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         num_q   <= '0;
         match_q <= '0;
         cyc_q   <= '0;
         fc_q    <= FC_NONE;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         num_q   <= num_d;
         match_q <= match_d;
         cyc_q   <= cyc_d;
         fc_q    <= fc_d;
      end
   end

   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
   assign pass      = (state_q == ST_PASS);
   assign fail_code = fc_q;
   assign match_cnt = match_q;
   assign cycles    = cyc_q;

endmodule

// File: tb/tb_store_checker.sv
// tb/tb_store_checker.sv - scoreboard bench for store_checker with a queue-based reference model
module tb_store_checker;

   localparam int DEPTH = 4;
   localparam int TO    = 16;
   localparam int IGN   = 80;

   typedef struct {
      logic       pass;
      logic [1:0] fc;
      int         mcnt;
      int         cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, start, tbl_we, memwrite;
   logic [1:0]  tbl_idx;
   logic [31:0] tbl_addr, tbl_data, dataadr, writedata;
   logic [2:0]  num_exp;
   logic        busy, done, pass;
   logic [1:0]  fail_code;
   logic [2:0]  match_cnt;
   logic [31:0] cycles;

   int n_tests = 0;
   int n_fail  = 0;

   exp_t        exp_q[$];
   logic        s_we [TO];
   logic [31:0] s_a  [TO];
   logic [31:0] s_d  [TO];
   logic [31:0] m_addr [DEPTH];
   logic [31:0] m_data [DEPTH];

   store_checker #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .TIMEOUT(TO),
      .IGNORE_EN(1), .IGNORE_ADDR(IGN)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
      .tbl_addr(tbl_addr), .tbl_data(tbl_data), .num_exp(num_exp), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .busy(busy), .done(done), .pass(pass),
      .fail_code(fail_code), .match_cnt(match_cnt), .cycles(cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Walk the store list cycle by cycle: in-order matches advance, scratch stores are tolerated,
   // anything else fails, and the TO-th run cycle times out unless it completes the list.
   function automatic exp_t model(input int num, output int last_c);
      exp_t e;
      int   k;
      k = 0;
      e.pass = 1'b0; e.fc = 2'd0; e.mcnt = 0; e.cyc = 0;
      last_c = -1;
      if (num == 0) begin
         e.pass = 1'b1;
         return e;
      end
      for (int c = 0; c < TO; c++) begin
         if (s_we[c]) begin
            if (s_a[c] == m_addr[k] && s_d[c] == m_data[k]) begin
               k++;
               if (k == num) begin
                  e.pass = 1'b1; e.mcnt = k; e.cyc = (c + 1 < TO - 1) ? c + 1 : TO - 1;
                  last_c = c;
                  return e;
               end
            end else if (s_a[c] != IGN) begin
               e.fc = 2'd1; e.mcnt = k; e.cyc = (c + 1 < TO - 1) ? c + 1 : TO - 1;
               last_c = c;
               return e;
            end
         end
         if (c == TO - 1) begin
            e.fc = 2'd2; e.mcnt = k; e.cyc = TO - 1;
            last_c = c;
            return e;
         end
      end
      return e;
   endfunction

   task automatic clr_seq();
      for (int c = 0; c < TO; c++) begin
         s_we[c] = 1'b0; s_a[c] = 32'd0; s_d[c] = 32'd0;
      end
   endtask

   task automatic set_st(input int c, input logic [31:0] a, input logic [31:0] d);
      s_we[c] = 1'b1; s_a[c] = a; s_d[c] = d;
   endtask

   task automatic gen_seq(input int num);
      int k;
      int r;
      k = 0;
      clr_seq();
      for (int c = 0; c < TO; c++) begin
         r = $urandom_range(0, 19);
         if (r >= 8 && r <= 16 && k < num) begin
            set_st(c, m_addr[k], m_data[k]);
            k++;
         end else if (r == 17 || r == 18) begin
            set_st(c, IGN, $urandom_range(0, 3));
         end else if (r == 19) begin
            set_st(c, 4 * $urandom_range(40, 60), $urandom_range(0, 3));
         end
      end
   endtask

   task automatic tbl_load(input int idx, input logic [31:0] a, input logic [31:0] d);
      tbl_we = 1'b1; tbl_idx = 2'(idx); tbl_addr = a; tbl_data = d;
      @(negedge clk);
      tbl_we = 1'b0;
      m_addr[idx] = a;
      m_data[idx] = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_fail_code"}, fail_code, 0);
      chk({tag, "_match_cnt"}, match_cnt, 0);
      chk({tag, "_cycles"}, cycles, 0);
   endtask

   task automatic do_run(input int num);
      exp_t e;
      int   last_c;
      int   w;
      e = model(num, last_c);
      exp_q.push_back(e);
      start = 1'b1; num_exp = 3'(num);
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c <= last_c; c++) begin
         memwrite = s_we[c]; dataadr = s_a[c]; writedata = s_d[c];
         @(negedge clk);
      end
      memwrite = 1'b0;
      w = 0;
      while (!done && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!done) chk("run_done_bound", done, 1);
   endtask

   initial begin : monitor
      exp_t e;
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done && !prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", done, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pass", pass, e.pass);
               chk("fail_code", fail_code, e.fc);
               chk("match_cnt", match_cnt, e.mcnt);
               chk("cycles", cycles, e.cyc);
               chk("busy_at_done", busy, 0);
            end
         end
         prev = done;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int num;
      reset = 1'b1; start = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
      num_exp = '0; memwrite = 1'b0; dataadr = '0; writedata = '0;
      repeat (2) @(negedge clk);
      chk_cleared("reset");
      reset = 1'b0;

      clr_seq();
      do_run(0);

      do_reset();
      tbl_load(0, 84, 8);
      clr_seq(); set_st(0, 80, 7); set_st(1, 84, 8);
      do_run(1);

      clr_seq(); set_st(0, 88, 8);
      do_run(1);

      clr_seq();
      do_run(1);

      do_reset();
      tbl_load(1, 88, 9);
      tbl_load(2, 92, 10);
      clr_seq(); set_st(0, 84, 8); set_st(1, 88, 9); set_st(2, 92, 10);
      do_run(3);
      clr_seq(); set_st(0, 84, 8); set_st(1, 92, 10);
      do_run(3);
      clr_seq(); set_st(13, 84, 8); set_st(14, 88, 9); set_st(15, 92, 10);
      do_run(3);

      // Mid-run reset, with table writes attempted while running and while reset is held.
      start = 1'b1; num_exp = 3'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      tbl_we = 1'b1; tbl_idx = 2'd0; tbl_addr = 32'd999; tbl_data = 32'd1;
      @(negedge clk);
      tbl_we = 1'b0;
      chk("busy_mid_run", busy, 1);
      reset = 1'b1; start = 1'b1; tbl_we = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0; tbl_we = 1'b0;
      chk_cleared("mid_run_reset");
      clr_seq(); set_st(0, 84, 8);
      do_run(1);

      for (int it = 0; it < 40; it++) begin
         if (it == 0 || $urandom_range(0, 3) == 0) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++)
               tbl_load(i, 4 * $urandom_range(19, 23), $urandom_range(0, 3));
         end
         num = $urandom_range(1, DEPTH);
         gen_seq(num);
         do_run(num);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
